// File: rtl/cmd_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_issue_sched
//  Purpose  : Tags requester commands, issues them through a one-entry register
//             and tracks out-of-order completions, HLT/RST drain and errors.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_issue_sched #(
    parameter int MAX_OUT     = 4,
    parameter int TAG_W       = 2,
    parameter int OPD_W       = 64,
    parameter int LATENCY_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [2:0]       req_cmd,
    input  logic [OPD_W-1:0] req_opd1,
    input  logic [OPD_W-1:0] req_opd2,
    output logic             iss_vld,
    input  logic             iss_rdy,
    output logic [2:0]       iss_cmd,
    output logic [TAG_W-1:0] iss_tag,
    output logic [OPD_W-1:0] iss_opd1,
    output logic [OPD_W-1:0] iss_opd2,
    input  logic             cpl_vld,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [2:0]       cpl_cmd,
    output logic [TAG_W:0]   outstanding,
    output logic             halted,
    output logic             err_timeout,
    output logic             err_cpl
);

    localparam int               AGE_W    = $clog2(LATENCY_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LATENCY_MAX);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(LATENCY_MAX - 1);
    localparam logic [2:0]       CMD_RST  = 3'd0;
    localparam logic [2:0]       CMD_INIT = 3'd1;
    localparam logic [2:0]       CMD_HLT  = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_OUT-1:0] busy_q, busy_d;
    logic [MAX_OUT-1:0] issued_q, issued_d;
    logic [2:0]         cmd_q [MAX_OUT];
    logic [2:0]         cmd_d [MAX_OUT];
    logic [AGE_W-1:0]   age_q [MAX_OUT];
    logic [AGE_W-1:0]   age_d [MAX_OUT];

    logic               iss_vld_q, iss_vld_d;
    logic [2:0]         iss_cmd_q, iss_cmd_d;
    logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
    logic [OPD_W-1:0]   iss_opd1_q, iss_opd1_d;
    logic [OPD_W-1:0]   iss_opd2_q, iss_opd2_d;
    logic [TAG_W:0]     outstanding_q, outstanding_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_cpl_q, err_cpl_d;

    logic               free_any;
    logic [TAG_W-1:0]   free_tag;
    logic               is_compute;
    logic               slot_ok;
    logic               idle;
    logic               acc;
    logic               acc_compute;
    logic               acc_hlt;
    logic               acc_rst;
    logic               hs;
    logic               cpl_bad;
    logic               tmo_any;

    // Lowest-index free tag; tags freed this cycle only become visible next cycle.
    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    assign is_compute = (req_cmd != CMD_RST) && (req_cmd != CMD_HLT);
    assign slot_ok    = free_any && (!iss_vld_q || iss_rdy);
    assign idle       = (outstanding_q == '0) && !iss_vld_q;

    always_comb begin
        req_rdy = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (req_cmd == CMD_HLT)      req_rdy = 1'b1;
                    else if (req_cmd == CMD_RST) req_rdy = idle;
                    else                         req_rdy = slot_ok;
                end
                ST_HALTED: req_rdy = (req_cmd == CMD_INIT) && slot_ok;
                default:   req_rdy = 1'b0;
            endcase
        end
    end

    assign acc         = req_vld && req_rdy;
    assign acc_compute = acc && is_compute;
    assign acc_hlt     = acc && (req_cmd == CMD_HLT);
    assign acc_rst     = acc && (req_cmd == CMD_RST);
    assign hs          = iss_vld_q && iss_rdy;

    // A tag issued this same cycle still has issued_q clear, so it is caught here too.
    assign cpl_bad = cpl_vld && (!busy_q[cpl_tag] || !issued_q[cpl_tag] ||
                                 (cmd_q[cpl_tag] != cpl_cmd));

    always_comb begin
        busy_d   = busy_q;
        issued_d = issued_q;
        tmo_any  = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            cmd_d[i] = cmd_q[i];
            age_d[i] = age_q[i];
            if (busy_q[i] && issued_q[i]) begin
                if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
                if ((age_q[i] == AGE_LAST) &&
                    !(cpl_vld && (cpl_tag == TAG_W'(i))))
                    tmo_any = 1'b1;
            end
            if (hs && (iss_tag_q == TAG_W'(i))) begin
                issued_d[i] = 1'b1;
                age_d[i]    = '0;
            end
            if (cpl_vld && (cpl_tag == TAG_W'(i))) begin
                busy_d[i]   = 1'b0;
                issued_d[i] = 1'b0;
                age_d[i]    = '0;
            end
            if (acc_compute && (free_tag == TAG_W'(i))) begin
                busy_d[i]   = 1'b1;
                issued_d[i] = 1'b0;
                cmd_d[i]    = req_cmd;
                age_d[i]    = '0;
            end
        end
    end

    always_comb begin
        outstanding_d = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            outstanding_d = outstanding_d + {{TAG_W{1'b0}}, busy_d[i]};
        end
    end

    always_comb begin
        iss_vld_d  = iss_vld_q;
        iss_cmd_d  = iss_cmd_q;
        iss_tag_d  = iss_tag_q;
        iss_opd1_d = iss_opd1_q;
        iss_opd2_d = iss_opd2_q;
        if (hs) iss_vld_d = 1'b0;
        if (acc_compute) begin
            iss_vld_d  = 1'b1;
            iss_cmd_d  = req_cmd;
            iss_tag_d  = free_tag;
            iss_opd1_d = req_opd1;
            iss_opd2_d = req_opd2;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (acc_hlt)     state_d = ST_DRAIN;
            ST_DRAIN:  if (idle)        state_d = ST_HALTED;
            ST_HALTED: if (acc_compute) state_d = ST_RUN;
            default:                    state_d = ST_RUN;
        endcase
    end

    // A new error in the same cycle as an RST command still lands.
    assign err_timeout_d = (err_timeout_q && !acc_rst) || tmo_any;
    assign err_cpl_d     = (err_cpl_q && !acc_rst) || cpl_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            busy_q        <= '0;
            issued_q      <= '0;
            iss_vld_q     <= 1'b0;
            iss_cmd_q     <= '0;
            iss_tag_q     <= '0;
            iss_opd1_q    <= '0;
            iss_opd2_q    <= '0;
            outstanding_q <= '0;
            err_timeout_q <= 1'b0;
            err_cpl_q     <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                cmd_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            issued_q      <= issued_d;
            iss_vld_q     <= iss_vld_d;
            iss_cmd_q     <= iss_cmd_d;
            iss_tag_q     <= iss_tag_d;
            iss_opd1_q    <= iss_opd1_d;
            iss_opd2_q    <= iss_opd2_d;
            outstanding_q <= outstanding_d;
            err_timeout_q <= err_timeout_d;
            err_cpl_q     <= err_cpl_d;
            for (int i = 0; i < MAX_OUT; i++) begin
                cmd_q[i] <= cmd_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign iss_vld     = iss_vld_q;
    assign iss_cmd     = iss_cmd_q;
    assign iss_tag     = iss_tag_q;
    assign iss_opd1    = iss_opd1_q;
    assign iss_opd2    = iss_opd2_q;
    assign outstanding = outstanding_q;
    assign halted      = (state_q == ST_HALTED);
    assign err_timeout = err_timeout_q;
    assign err_cpl     = err_cpl_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_issue_sched
//  Purpose  : Directed and random stimulus for cmd_issue_sched against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_issue_sched;

    localparam int MAX_OUT = 4;
    localparam int TAG_W   = 2;
    localparam int OPD_W   = 64;
    localparam int LAT     = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_vld = 1'b0;
    logic             req_rdy;
    logic [2:0]       req_cmd = '0;
    logic [OPD_W-1:0] req_opd1 = '0;
    logic [OPD_W-1:0] req_opd2 = '0;
    logic             iss_vld;
    logic             iss_rdy = 1'b0;
    logic [2:0]       iss_cmd;
    logic [TAG_W-1:0] iss_tag;
    logic [OPD_W-1:0] iss_opd1;
    logic [OPD_W-1:0] iss_opd2;
    logic             cpl_vld = 1'b0;
    logic [TAG_W-1:0] cpl_tag = '0;
    logic [2:0]       cpl_cmd = '0;
    logic [TAG_W:0]   outstanding;
    logic             halted;
    logic             err_timeout;
    logic             err_cpl;

    always #5 clk = ~clk;

    cmd_issue_sched #(
        .MAX_OUT(MAX_OUT), .TAG_W(TAG_W), .OPD_W(OPD_W), .LATENCY_MAX(LAT)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_cmd(req_cmd),
        .req_opd1(req_opd1), .req_opd2(req_opd2),
        .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_cmd(iss_cmd), .iss_tag(iss_tag),
        .iss_opd1(iss_opd1), .iss_opd2(iss_opd2),
        .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd),
        .outstanding(outstanding), .halted(halted),
        .err_timeout(err_timeout), .err_cpl(err_cpl)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tags as a busy table holding the edge number of their
    // issue handshake; latency is measured as a difference of edge numbers.
    int               m_mode;      // 0 run, 1 drain, 2 halted
    bit               m_busy   [MAX_OUT];
    int               m_iss_at [MAX_OUT];
    int               m_cmd    [MAX_OUT];
    bit               p_vld;
    logic [2:0]       p_cmd;
    logic [TAG_W-1:0] p_tag;
    logic [63:0]      p_a, p_b;
    bit               m_eto, m_ecpl;
    int               edge_n = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < MAX_OUT; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < MAX_OUT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit m_rdy();
        bit room = (m_first_free() >= 0) && (!p_vld || iss_rdy);
        if (rst) return 1'b0;
        if (m_mode == 0) begin
            if (req_cmd == 3'd7) return 1'b1;
            if (req_cmd == 3'd0) return (m_count() == 0) && !p_vld;
            return room;
        end
        if (m_mode == 2) return (req_cmd == 3'd1) && room;
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_mode = 0;
        for (int i = 0; i < MAX_OUT; i++) begin
            m_busy[i] = 0; m_iss_at[i] = -1; m_cmd[i] = 0;
        end
        p_vld = 0; p_cmd = '0; p_tag = '0; p_a = '0; p_b = '0;
        m_eto = 0; m_ecpl = 0;
    endtask

    task automatic m_edge();
        int  cnt, ff, t;
        bit  acc, hs, to_new, cp_new, clr, pv;
        edge_n++;
        if (rst) begin
            m_reset();
            return;
        end
        cnt = m_count();
        ff  = m_first_free();
        acc = req_vld && m_rdy();
        hs  = p_vld && iss_rdy;
        pv  = p_vld;
        t   = int'(cpl_tag);
        cp_new = cpl_vld && (!m_busy[t] || (m_iss_at[t] < 0) || (m_cmd[t] != int'(cpl_cmd)));
        to_new = 0;
        for (int i = 0; i < MAX_OUT; i++)
            if (m_busy[i] && (m_iss_at[i] >= 0) && !(cpl_vld && t == i) &&
                (edge_n - m_iss_at[i] >= LAT))
                to_new = 1;
        clr = acc && (req_cmd == 3'd0);
        if (hs) begin
            m_iss_at[int'(p_tag)] = edge_n;
            p_vld = 0;
        end
        if (cpl_vld && m_busy[t]) begin
            m_busy[t] = 0;
            m_iss_at[t] = -1;
        end
        if (acc && req_cmd >= 3'd1 && req_cmd <= 3'd6) begin
            m_busy[ff] = 1; m_iss_at[ff] = -1; m_cmd[ff] = int'(req_cmd);
            p_vld = 1; p_cmd = req_cmd; p_tag = TAG_W'(ff); p_a = req_opd1; p_b = req_opd2;
        end
        m_eto  = (m_eto && !clr) || to_new;
        m_ecpl = (m_ecpl && !clr) || cp_new;
        case (m_mode)
            0: if (acc && req_cmd == 3'd7) m_mode = 1;
            1: if (cnt == 0 && !pv)        m_mode = 2;
            2: if (acc)                    m_mode = 0;
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_regs();
        chk("iss_vld", iss_vld, p_vld);
        chk("iss_cmd", iss_cmd, p_cmd);
        chk("iss_tag", iss_tag, p_tag);
        chk("iss_opd1", iss_opd1, p_a);
        chk("iss_opd2", iss_opd2, p_b);
        chk("outstanding", outstanding, m_count());
        chk("halted", halted, m_mode == 2);
        chk("err_timeout", err_timeout, m_eto);
        chk("err_cpl", err_cpl, m_ecpl);
    endtask

    task automatic cyc(input bit v, input logic [2:0] c, input logic [63:0] a,
                       input logic [63:0] b, input bit ir, input bit cv,
                       input logic [TAG_W-1:0] ct, input logic [2:0] cc);
        req_vld = v; req_cmd = c; req_opd1 = a; req_opd2 = b;
        iss_rdy = ir; cpl_vld = cv; cpl_tag = ct; cpl_cmd = cc;
        @(negedge clk);
        chk("req_rdy", req_rdy, m_rdy());
        @(posedge clk);
        m_edge();
        #1;
        check_regs();
    endtask

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) cyc(0, 3'd0, 64'd0, 64'd0, ir, 0, '0, 3'd0);
    endtask

    task automatic send(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        cyc(1, c, a, b, 1, 0, '0, 3'd0);
    endtask

    task automatic cpl(input logic [TAG_W-1:0] t, input logic [2:0] c);
        cyc(0, 3'd0, 64'd0, 64'd0, 1, 1, t, c);
    endtask

    initial begin
        int r;
        int cand[$];
        m_reset();
        rst = 1'b1;
        idle(2, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_iss_vld", iss_vld, 0);
        rst = 1'b0;

        // single ADD, completed three cycles after issue
        send(3'd2, 64'd5, 64'd3);
        chk("tp1_tag", iss_tag, 0);
        chk("tp1_opd1", iss_opd1, 5);
        idle(2, 1);
        cpl(0, 3'd2);
        chk("tp1_done", outstanding, 0);

        // fill all tags, full back-pressure, reuse of a freed tag
        send(3'd2, 64'd1, 64'd1);
        send(3'd3, 64'd2, 64'd2);
        send(3'd4, 64'd3, 64'd3);
        send(3'd5, 64'd4, 64'd4);
        chk("tp2_tag3", iss_tag, 3);
        send(3'd2, 64'd9, 64'd9);
        chk("tp2_full", outstanding, 4);
        cpl(2, 3'd4);
        send(3'd2, 64'd7, 64'd7);
        chk("tp2_reuse", iss_tag, 2);
        idle(1, 1);
        cpl(0, 3'd2); cpl(1, 3'd3); cpl(2, 3'd2); cpl(3, 3'd5);

        // out-of-order completion
        send(3'd3, 64'd10, 64'd1);
        send(3'd5, 64'd20, 64'd2);
        send(3'd6, 64'd30, 64'd3);
        idle(1, 1);
        cpl(2, 3'd6); cpl(0, 3'd3); cpl(1, 3'd5);
        chk("tp3_errcpl", err_cpl, 0);

        // HLT drain, hold-off, INIT restart
        send(3'd2, 64'd1, 64'd2);
        send(3'd2, 64'd3, 64'd4);
        send(3'd7, 64'd0, 64'd0);
        cyc(1, 3'd2, 64'd5, 64'd5, 1, 0, '0, 3'd0);
        cpl(0, 3'd2);
        cpl(1, 3'd2);
        chk("tp4_not_yet", halted, 0);
        idle(1, 1);
        chk("tp4_halted", halted, 1);
        cyc(1, 3'd2, 64'd5, 64'd5, 1, 0, '0, 3'd0);
        cyc(1, 3'd2, 64'd5, 64'd5, 1, 0, '0, 3'd0);
        send(3'd1, 64'd11, 64'd12);
        chk("tp4_init", iss_cmd, 1);
        idle(1, 1);
        cpl(0, 3'd1);

        // timeout exactly LAT cycles after handshake, bad completion, RST clears
        send(3'd4, 64'd6, 64'd7);
        idle(1, 1);
        idle(LAT - 1, 1);
        chk("tp5_early", err_timeout, 0);
        idle(1, 1);
        chk("tp5_tmo", err_timeout, 1);
        cpl(3, 3'd4);
        chk("tp5_errcpl", err_cpl, 1);
        cpl(0, 3'd4);
        send(3'd0, 64'd0, 64'd0);
        chk("tp5_clr_to", err_timeout, 0);
        chk("tp5_clr_cpl", err_cpl, 0);

        // stall, reset mid-stall, stale completion
        cyc(1, 3'd2, 64'hAA, 64'hBB, 0, 0, '0, 3'd0);
        for (int i = 0; i < 5; i++) cyc(1, 3'd3, 64'd1, 64'd1, 0, 0, '0, 3'd0);
        chk("tp6_hold", iss_opd1, 64'hAA);
        rst = 1'b1;
        cyc(0, 3'd0, 64'd0, 64'd0, 0, 0, '0, 3'd0);
        chk("tp6_rst_vld", iss_vld, 0);
        chk("tp6_rst_out", outstanding, 0);
        rst = 1'b0;
        cpl(0, 3'd2);
        chk("tp6_stale", err_cpl, 1);
        send(3'd0, 64'd0, 64'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [2:0]       c;
            logic [TAG_W-1:0] ct;
            logic [2:0]       cc;
            bit               cv;
            r = $urandom_range(0, 99);
            if (r < 80)      c = 3'($urandom_range(1, 6));
            else if (r < 87) c = 3'd7;
            else if (r < 93) c = 3'd0;
            else             c = 3'd1;
            cand.delete();
            for (int i = 0; i < MAX_OUT; i++)
                if (m_busy[i] && m_iss_at[i] >= 0) cand.push_back(i);
            r = $urandom_range(0, 99);
            cv = 0; ct = '0; cc = '0;
            if (r < 35 && cand.size() > 0) begin
                cv = 1;
                ct = TAG_W'(cand[$urandom_range(0, cand.size() - 1)]);
                cc = 3'(m_cmd[int'(ct)]);
            end else if (r < 39) begin
                cv = 1;
                ct = TAG_W'($urandom_range(0, MAX_OUT - 1));
                cc = 3'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 99) < 60, c, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 99) < 70, cv, ct, cc);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_issue_sched.md
Name: cmd_issue_sched

Overview:
Scheduler between one command requester and the shared arithmetic execution unit, which runs INIT/ADD/SUB/MULT/DIV/REM. It accepts commands by valid/ready and assigns each a tag. It issues commands through a one-entry output register and tracks up to MAX_OUT outstanding commands that complete out of order. It enforces HLT/RST drain rules and flags completion-latency and protocol errors.

Parameters:
MAX_OUT, 4, max outstanding tags (2..8)
TAG_W, 2, tag width, must equal clog2(MAX_OUT)
OPD_W, 64, operand width
LATENCY_MAX, 7, max cycles from issue handshake to completion

Ports:
clk  in  1  clock
rst  in  1  reset
req_vld  in  1  requester command valid
req_rdy  out  1  scheduler accepts command
req_cmd  in  3  RST=0 INIT=1 ADD=2 SUB=3 MULT=4 DIV=5 REM=6 HLT=7
req_opd1  in  OPD_W  operand 1
req_opd2  in  OPD_W  operand 2
iss_vld  out  1  command to execution unit valid
iss_rdy  in  1  execution unit accepts
iss_cmd  out  3  issued command
iss_tag  out  TAG_W  issued tag
iss_opd1  out  OPD_W  issued operand 1
iss_opd2  out  OPD_W  issued operand 2
cpl_vld  in  1  completion strobe
cpl_tag  in  TAG_W  completing tag
cpl_cmd  in  3  completing command
outstanding  out  TAG_W+1  count of busy tags
halted  out  1  FSM in HALTED
err_timeout  out  1  sticky: a tag exceeded LATENCY_MAX
err_cpl  out  1  sticky: illegal completion

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset all outputs are 0, all tag state is cleared, FSM goes to RUN, and sticky errors are cleared.
- Per-tag state: busy, issued, cmd[2:0], age counter. The age counter is clog2(LATENCY_MAX+1) bits and saturates.
- FSM states: RUN, DRAIN, HALTED.
  - RUN, HLT accepted: go to DRAIN.
  - DRAIN, outstanding==0 and iss_vld==0: go to HALTED.
  - HALTED, INIT accepted: go to RUN.
- req_rdy, computed combinationally from req_cmd:
  - RUN, compute cmds 1..6: free tag exists and (!iss_vld || iss_rdy).
  - RUN, HLT: always 1.
  - RUN, RST: only when outstanding==0 and iss_vld==0.
  - DRAIN: 0.
  - HALTED: 1 only for INIT (same free-tag/issue conditions); otherwise 0.
- Accept of a compute cmd:
  - Allocate the lowest-index free tag: busy=1, issued=0, store cmd.
  - Load the issue register; iss_vld=1 on the next cycle.
  - The issue register holds stable while iss_vld && !iss_rdy.
- Accept of HLT or RST: consumed locally, never issued. RST also clears both sticky errors.
- Issue handshake (iss_vld && iss_rdy): mark the tag issued, set age=0, and clear iss_vld unless a new command is accepted in the same cycle.
- Age: increments each cycle while issued and busy. If age reaches LATENCY_MAX without completion, err_timeout=1; the tag stays busy.
- Completion (cpl_vld):
  - err_cpl=1 if the tag is not busy, not yet issued, issued this same cycle, or cpl_cmd differs from the stored cmd.
  - In every case a busy tag is freed.
  - A freed tag is allocatable from the next cycle; no same-cycle bypass.
- Simultaneous accept and completion: outstanding changes by net +1-1=0. Completion freeing the last busy tag in DRAIN gives HALTED one cycle later.
- Full: outstanding==MAX_OUT, so req_rdy=0 for compute cmds.
- Tags carry no order; completions in any order are legal.
- outstanding is registered and equals popcount(busy).

Test Plan:
- Reset, then ADD(5,3) with iss_rdy=1 -> iss_vld on the next cycle with iss_tag=0, iss_cmd=2, iss_opd1=5, iss_opd2=3. cpl tag0/ADD 3 cycles later -> outstanding 1 then 0, no errors.
- Four cmds back-to-back with no completion -> tags 0,1,2,3, fifth req_rdy=0. Complete tag2 -> next accept gets tag2.
- Issue SUB, DIV, REM; complete in order REM, SUB, DIV -> no err_cpl, outstanding returns to 0.
- Two outstanding, then HLT -> DRAIN, req_rdy=0. Both complete -> halted=1 the following cycle. ADD is held off; INIT is accepted -> RUN, INIT issued.
- Issued MULT never completes -> err_timeout=1 exactly LATENCY_MAX=7 cycles after the handshake. cpl_tag=3 while tag3 is free -> err_cpl=1. Drain and then RST cmd -> both errors clear.
- iss_rdy=0 for 5 cycles -> iss_* stable and req_rdy=0 for compute cmds. Assert rst mid-stall -> all outputs 0 next cycle; a stale completion afterwards gives err_cpl=1.
